// File: rtl/apb_tan_pkg.sv
// Purpose : shared types and constants for the APB tangent scheduler.
// Latency : n/a (package only).
// Backpr. : n/a.
// Contents: state_t job FSM encoding, default register addresses.
package apb_tan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_ACCESS,
    R_SETUP,
    R_ACCESS,
    RESP
  } state_t;

  localparam logic [31:0] ADDR_CTRL_DEF = 32'h0000_0000;
  localparam logic [31:0] ADDR_OUT_DEF  = 32'h0000_0004;

endpackage

// File: rtl/apb_tan_scheduler_if.sv
// Purpose : groups the requester handshake, result and APB master signals.
// Latency : n/a (wiring only).
// Backpr. : req_ready is the only backpressure; results cannot be stalled.
// Ports   : master = scheduler side, slave = requesters + APB slave side.
interface apb_tan_scheduler_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32
);
  localparam int ID_W = $clog2(N_REQ);

  // requesters
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_n;
  logic [N_REQ-1:0]        req_ready;
  // tagged result
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_err;
  // APB
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [DATA_W-1:0]       PADDR;
  logic [DATA_W-1:0]       PWDATA;
  logic [DATA_W-1:0]       PRDATA;
  logic                    PREADY;

  modport master (
    input  req_valid, req_n, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_n, PRDATA, PREADY,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/rr_arbiter.sv
// Purpose : round-robin pick of one request, searching upward from ptr with wrap.
// Latency : combinational, no state (pointer lives in the parent).
// Backpr. : none; gnt is all-zero when no request is pending.
// Ports   : req (pending bits), ptr (search start), gnt (one-hot), gnt_id (index of gnt).
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id
);

  logic            found;
  int              idx_i;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx_i  = 0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // modulo keeps the wrap correct for non-power-of-two N_REQ
      idx_i = (int'(ptr) + i) % N_REQ;
      idx   = ID_W'(idx_i);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/apb_tan_scheduler.sv
// Purpose : APB master sharing the tangent slave between N_REQ requesters (write n, read result).
// Latency : handshake edge k -> rsp_valid in cycle k+5 with a zero-wait slave, +1 per wait state.
// Backpr. : one job at a time, req_ready only in IDLE; results are a 1-cycle pulse, never stalled.
// Ports   : PCLK/PRESET (sync, active high), bus = apb_tan_scheduler_if.master.
module apb_tan_scheduler
  import apb_tan_pkg::*;
#(
  parameter int                N_REQ     = 2,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] ADDR_CTRL = DATA_W'(ADDR_CTRL_DEF),
  parameter logic [DATA_W-1:0] ADDR_OUT  = DATA_W'(ADDR_OUT_DEF),
  parameter int                TIMEOUT   = 16
) (
  input logic                  PCLK,
  input logic                  PRESET,
  apb_tan_scheduler_if.master  bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic [N_REQ-1:0]    gnt;
  logic [ID_W-1:0]     gnt_id;
  logic                expired;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req    (bus.req_valid),
    .ptr    (rr_ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // grant is only offered while idle, so req_valid & req_ready is the handshake
  assign bus.req_ready = (state_q == IDLE) ? gnt : '0;

  // counter holds the number of ACCESS cycles already spent without PREADY
  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (|gnt) begin
          id_d     = gnt_id;
          rr_ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
          // PWDATA doubles as the job's operand register; it holds n through the read
          pwdata_d = bus.req_n[int'(gnt_id)*DATA_W +: DATA_W];
          paddr_d  = ADDR_CTRL;
          state_d  = W_SETUP;
        end
      end
      W_SETUP: begin
        cnt_d   = '0;
        state_d = W_ACCESS;
      end
      W_ACCESS: begin
        if (bus.PREADY) begin
          paddr_d = ADDR_OUT;
          state_d = R_SETUP;
        end else if (expired) begin
          // aborted write: the read is skipped entirely
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      R_SETUP: begin
        cnt_d   = '0;
        state_d = R_ACCESS;
      end
      R_ACCESS: begin
        if (bus.PREADY) begin
          rsp_err_d  = 1'b0;
          rsp_data_d = bus.PRDATA;
          state_d    = RESP;
        end else if (expired) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // bus controls registered from the next state so they line up with state_q
    psel_d      = (state_d != IDLE) && (state_d != RESP);
    penable_d   = (state_d == W_ACCESS) || (state_d == R_ACCESS);
    pwrite_d    = (state_d == W_SETUP) || (state_d == W_ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_tan_scheduler.sv
// Purpose : bench for apb_tan_scheduler with a behavioural APB tangent slave and a response scoreboard.
// Latency : n/a.
// Backpr. : slave wait states programmable (wait_n) or infinite (hang).
module tb_apb_tan_scheduler;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_tan_scheduler_if #(.N_REQ(N), .DATA_W(W)) bus ();

  apb_tan_scheduler #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus.master)
  );

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
    int          t0;
    int          lat;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  exp_t        sb[$];
  xfer_t       xlog[$];
  int          grant_log[$];
  exp_t        mon_e;
  xfer_t       xf;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          hs_count = 0;
  bit          busy = 1'b0;
  int          ptr_m = 0;
  int          wait_n = 0;
  bit          hang = 1'b0;
  int          acc_cnt = 0;
  logic [31:0] op = '0;
  int          pen_all = 0;
  int          pen_w = 0;
  int          hs_id;
  logic [N-1:0] exp_rdy;

  function automatic logic [31:0] f(input logic [31:0] n);
    case (n)
      32'd1:   return 32'h0000_0001;
      32'd2:   return 32'h7FFF_FFFF;
      32'd3:   return 32'hFFFF_FFFF;
      32'd4:   return 32'h0000_0000;
      default: return (n * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  function automatic logic [N-1:0] rr_model(input logic [N-1:0] req, input int p);
    logic [N-1:0] g;
    g = '0;
    for (int i = 0; i < N; i++) begin
      if (g == '0 && req[(p + i) % N]) g[(p + i) % N] = 1'b1;
    end
    return g;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural APB slave ----------------
  assign bus.PREADY = !hang && (acc_cnt == wait_n);
  assign bus.PRDATA = (bus.PSEL && bus.PENABLE && !bus.PWRITE && bus.PREADY) ? f(op) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      acc_cnt <= 0;
    end else begin
      if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
      else                                        acc_cnt <= 0;
      if (bus.PSEL && bus.PENABLE) begin
        pen_all++;
        if (bus.PWRITE) pen_w++;
      end
      if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
        xf.w    = bus.PWRITE;
        xf.addr = bus.PADDR;
        xf.data = bus.PWRITE ? bus.PWDATA : bus.PRDATA;
        xlog.push_back(xf);
        if (bus.PWRITE && bus.PADDR == 32'h0) op <= bus.PWDATA;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && bus.req_valid != '0) begin
      exp_rdy = busy ? '0 : rr_model(bus.req_valid, ptr_m);
      check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    end
    if (!rst && |(bus.req_valid & bus.req_ready)) begin
      hs_id = 0;
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) hs_id = i;
      mon_e.id   = hs_id;
      mon_e.err  = hang;
      mon_e.data = hang ? 32'h0 : f(bus.req_n[hs_id*W +: W]);
      mon_e.t0   = cyc;
      mon_e.lat  = hang ? (2 + TO) : (5 + 2 * wait_n);
      sb.push_back(mon_e);
      grant_log.push_back(hs_id);
      hs_count++;
      busy  = 1'b1;
      ptr_m = (hs_id + 1) % N;
    end
    if (bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id", 64'(bus.rsp_id), 64'(mon_e.id));
        check("rsp_data", 64'(bus.rsp_data), 64'(mon_e.data));
        check("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
        check("rsp_latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
      end
      busy = 1'b0;
    end
    if (rst) begin
      busy  = 1'b0;
      ptr_m = 0;
      sb.delete();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_hs(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (hs_count >= target) begin ok = 1'b1; break; end
    end
    #1;
    check("handshake_wait", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (!busy) break;
    end
    #1;
    check("response_wait", 64'(busy), 64'd0);
  endtask

  task automatic do_req(input int id, input logic [31:0] n);
    bus.req_n[id*W +: W] = n;
    bus.req_valid[id]    = 1'b1;
    wait_hs(hs_count + 1);
    bus.req_valid[id]    = 1'b0;
    // operand must have been captured at the handshake
    bus.req_n[id*W +: W] = ~n;
    wait_idle();
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_PSEL"},      64'(bus.PSEL), 64'd0);
    check({pfx, "_PENABLE"},   64'(bus.PENABLE), 64'd0);
    check({pfx, "_PWRITE"},    64'(bus.PWRITE), 64'd0);
    check({pfx, "_PADDR"},     64'(bus.PADDR), 64'd0);
    check({pfx, "_PWDATA"},    64'(bus.PWDATA), 64'd0);
    check({pfx, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({pfx, "_rsp_id"},    64'(bus.rsp_id), 64'd0);
    check({pfx, "_rsp_data"},  64'(bus.rsp_data), 64'd0);
    check({pfx, "_rsp_err"},   64'(bus.rsp_err), 64'd0);
    check({pfx, "_req_ready"}, 64'(bus.req_ready), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int  g0;
    bit  found;
    bus.req_valid = '0;
    bus.req_n     = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // 1: zero-wait single job, req0 n=1
    @(posedge clk); #1;
    xlog.delete();
    do_req(0, 32'd1);
    check("t1_xfer_count", 64'(xlog.size()), 64'd2);
    if (xlog.size() == 2) begin
      check("t1_wr_dir",  64'(xlog[0].w), 64'd1);
      check("t1_wr_addr", 64'(xlog[0].addr), 64'h0);
      check("t1_wr_data", 64'(xlog[0].data), 64'd1);
      check("t1_rd_dir",  64'(xlog[1].w), 64'd0);
      check("t1_rd_addr", 64'(xlog[1].addr), 64'h4);
      check("t1_rd_data", 64'(xlog[1].data), 64'd1);
    end
    do_req(1, 32'd4);

    // 2: req0 and req1 held together, four grants alternate 0,1,0,1
    g0 = grant_log.size();
    bus.req_n[0*W +: W] = 32'd3;
    bus.req_n[1*W +: W] = 32'd4;
    bus.req_valid[0] = 1'b1;
    bus.req_valid[1] = 1'b1;
    wait_hs(hs_count + 4);
    bus.req_valid = '0;
    wait_idle();
    check("t2_grant_count", 64'(grant_log.size() - g0), 64'd4);
    if (grant_log.size() - g0 == 4) begin
      check("t2_grant0", 64'(grant_log[g0]),     64'd0);
      check("t2_grant1", 64'(grant_log[g0 + 1]), 64'd1);
      check("t2_grant2", 64'(grant_log[g0 + 2]), 64'd0);
      check("t2_grant3", 64'(grant_log[g0 + 3]), 64'd1);
    end

    // 3: three wait states on every access
    wait_n  = 3;
    pen_all = 0;
    do_req(0, 32'd2);
    check("t3_penable_cycles", 64'(pen_all), 64'd8);
    wait_n = 0;

    // 4: write never acknowledged -> timeout abort, no read
    hang  = 1'b1;
    pen_w = 0;
    xlog.delete();
    do_req(1, 32'd5);
    check("t4_w_access_cycles", 64'(pen_w), 64'(TO));
    check("t4_no_transfers", 64'(xlog.size()), 64'd0);
    hang = 1'b0;
    do_req(0, 32'd1);

    // 5: reset pulsed during R_ACCESS
    wait_n = 3;
    bus.req_n[0*W +: W] = 32'd3;
    bus.req_valid[0] = 1'b1;
    wait_hs(hs_count + 1);
    bus.req_valid[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.PSEL && bus.PENABLE && !bus.PWRITE) begin found = 1'b1; break; end
    end
    check("t5_reached_r_access", 64'(found), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    wait_n = 0;
    @(negedge clk);
    check_all_zero("t5_after_reset");
    // pointer back at 0: with req0 and req1 both pending req0 wins first
    g0 = grant_log.size();
    bus.req_n[0*W +: W] = 32'd1;
    bus.req_n[1*W +: W] = 32'd2;
    bus.req_valid[0] = 1'b1;
    bus.req_valid[1] = 1'b1;
    wait_hs(hs_count + 2);
    bus.req_valid = '0;
    wait_idle();
    check("t5_grant_count", 64'(grant_log.size() - g0), 64'd2);
    if (grant_log.size() - g0 == 2) begin
      check("t5_grant0", 64'(grant_log[g0]),     64'd0);
      check("t5_grant1", 64'(grant_log[g0 + 1]), 64'd1);
    end

    // 6: only req3, then only req0 (pointer wraps)
    do_req(3, 32'd6);
    check("t6_grant_req3", 64'(grant_log[grant_log.size() - 1]), 64'd3);
    do_req(0, 32'd7);
    check("t6_grant_req0", 64'(grant_log[grant_log.size() - 1]), 64'd0);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
